// File: rtl/acc_multibank_if.sv
// Bundles the accumulate, bias, drain and error signals of acc_multibank.
interface acc_multibank_if #(
  parameter int NUM_BANKS = 4,
  parameter int ROWS      = 16,
  parameter int COLS      = 8,
  parameter int ACC_WIDTH = 32
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(ROWS);

  logic                      acc_valid;
  logic [BANK_W-1:0]         acc_bank;
  logic [COLS*ACC_WIDTH-1:0] acc_data;
  logic                      bias_valid;
  logic [BANK_W-1:0]         bias_bank;
  logic [COLS*ACC_WIDTH-1:0] bias_data;
  logic                      relu_en;
  logic                      drain_start;
  logic [BANK_W-1:0]         drain_bank;
  logic                      drain_busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*ACC_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]          out_row;
  logic                      err_clear;
  logic                      conflict_err;

  modport master (
    output acc_valid, acc_bank, acc_data, bias_valid, bias_bank, bias_data,
           relu_en, drain_start, drain_bank, out_ready, err_clear,
    input  drain_busy, out_valid, out_data, out_row, conflict_err
  );

  modport slave (
    input  acc_valid, acc_bank, acc_data, bias_valid, bias_bank, bias_data,
           relu_en, drain_start, drain_bank, out_ready, err_clear,
    output drain_busy, out_valid, out_data, out_row, conflict_err
  );
endinterface

// File: rtl/acc_multibank.sv
// Multi-bank accumulator: adder writes back ACC_LATENCY edges after issue; drain is valid/ready with read-clear.
// Define ACC_SAT_EN to saturate adder results on signed overflow instead of wrapping.
module acc_multibank #(
  parameter int NUM_BANKS   = 4,
  parameter int ROWS        = 16,
  parameter int COLS        = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int ACC_LATENCY = 2
) (
  input logic            clk,
  input logic            reset,
  acc_multibank_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int DW     = COLS * ACC_WIDTH;

  if (ACC_LATENCY < 1 || ACC_LATENCY > ROWS - 1 || NUM_BANKS < 2 || ROWS < 2) begin : g_bad_param
    $error("acc_multibank: ACC_LATENCY must be 1..ROWS-1, NUM_BANKS and ROWS at least 2");
  end

  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ACC_WIDTH-1:0] mem [NUM_BANKS][ROWS][COLS];
  logic [ROW_W-1:0]     wr_ptr [NUM_BANKS];

  logic [ACC_LATENCY-1:0] p_vld;
  logic [BANK_W-1:0]      p_bank [ACC_LATENCY];
  logic [ROW_W-1:0]       p_row  [ACC_LATENCY];
  logic [DW-1:0]          p_sum  [ACC_LATENCY];

  logic [BANK_W-1:0] d_bank;
  logic              ov_q;
  logic [DW-1:0]     od_q;
  logic [ROW_W-1:0]  orow_q;
  logic              err_q;

  logic              inflight, start_ok, start_err, hs, last_hs;
  logic              lock_vld, acc_err, acc_ok, bias_err, bias_ok;
  logic [BANK_W-1:0] lock_bank, rd_bank;
  logic [ROW_W-1:0]  rd_row;
  logic [DW-1:0]     sum_row, rd_dat;

  function automatic logic [ACC_WIDTH-1:0] add_lane(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
`ifdef ACC_SAT_EN
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  // Any pipeline stage still owing a write to the requested bank blocks the drain.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < ACC_LATENCY; i++)
      if (p_vld[i] && p_bank[i] == bus.drain_bank) inflight = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_err = 1'b0;
    last_hs   = 1'b0;
    hs        = ov_q && bus.out_ready;
    case (state)
      IDLE: begin
        if (bus.drain_start) begin
          if (inflight) begin
            start_err = 1'b1;
          end else begin
            start_ok  = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.drain_start) start_err = 1'b1;
        if (hs && orow_q == ROW_W'(ROWS - 1)) begin
          last_hs   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The bank being started this cycle is locked too, so row 0 is never written under the drain.
  assign lock_vld  = (state == DRAIN) || start_ok;
  assign lock_bank = (state == DRAIN) ? d_bank : bus.drain_bank;
  assign acc_err   = bus.acc_valid && lock_vld && bus.acc_bank == lock_bank;
  assign acc_ok    = bus.acc_valid && !acc_err;
  assign bias_err  = bus.bias_valid && ((lock_vld && bus.bias_bank == lock_bank) ||
                                        (bus.acc_valid && bus.acc_bank == bus.bias_bank));
  assign bias_ok   = bus.bias_valid && !bias_err;

  always_comb begin
    sum_row = '0;
    for (int l = 0; l < COLS; l++)
      sum_row[l*ACC_WIDTH +: ACC_WIDTH] = add_lane(mem[bus.acc_bank][wr_ptr[bus.acc_bank]][l],
                                                   bus.acc_data[l*ACC_WIDTH +: ACC_WIDTH]);
  end

  assign rd_bank = start_ok ? bus.drain_bank : d_bank;
  assign rd_row  = start_ok ? '0 : orow_q + 1'b1;

  always_comb begin
    rd_dat = '0;
    for (int l = 0; l < COLS; l++) begin
      rd_dat[l*ACC_WIDTH +: ACC_WIDTH] = mem[rd_bank][rd_row][l];
      if (bus.relu_en && mem[rd_bank][rd_row][l][ACC_WIDTH-1])
        rd_dat[l*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        wr_ptr[b] <= '0;
        for (int r = 0; r < ROWS; r++)
          for (int l = 0; l < COLS; l++)
            mem[b][r][l] <= '0;
      end
      p_vld <= '0;
      for (int i = 0; i < ACC_LATENCY; i++) begin
        p_bank[i] <= '0;
        p_row[i]  <= '0;
        p_sum[i]  <= '0;
      end
      d_bank <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      orow_q <= '0;
      err_q  <= 1'b0;
    end else begin
      p_vld[0]  <= acc_ok;
      p_bank[0] <= bus.acc_bank;
      p_row[0]  <= wr_ptr[bus.acc_bank];
      p_sum[0]  <= sum_row;
      for (int i = 1; i < ACC_LATENCY; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_bank[i] <= p_bank[i-1];
        p_row[i]  <= p_row[i-1];
        p_sum[i]  <= p_sum[i-1];
      end
      if (p_vld[ACC_LATENCY-1])
        for (int l = 0; l < COLS; l++)
          mem[p_bank[ACC_LATENCY-1]][p_row[ACC_LATENCY-1]][l] <= p_sum[ACC_LATENCY-1][l*ACC_WIDTH +: ACC_WIDTH];
      if (bias_ok)
        for (int l = 0; l < COLS; l++)
          mem[bus.bias_bank][wr_ptr[bus.bias_bank]][l] <= bus.bias_data[l*ACC_WIDTH +: ACC_WIDTH];

      for (int b = 0; b < NUM_BANKS; b++) begin
        if (last_hs && d_bank == BANK_W'(b))
          wr_ptr[b] <= '0;
        else if ((acc_ok && bus.acc_bank == BANK_W'(b)) || (bias_ok && bus.bias_bank == BANK_W'(b)))
          wr_ptr[b] <= (wr_ptr[b] == ROW_W'(ROWS - 1)) ? '0 : wr_ptr[b] + 1'b1;
      end

      if (start_ok) begin
        d_bank <= bus.drain_bank;
        ov_q   <= 1'b1;
        orow_q <= '0;
        od_q   <= rd_dat;
      end else if (hs) begin
        for (int l = 0; l < COLS; l++)
          mem[d_bank][orow_q][l] <= '0;
        if (last_hs) begin
          ov_q <= 1'b0;
        end else begin
          orow_q <= orow_q + 1'b1;
          od_q   <= rd_dat;
        end
      end

      if (bus.err_clear)                          err_q <= 1'b0;
      else if (acc_err || bias_err || start_err)  err_q <= 1'b1;
    end
  end

  assign bus.drain_busy   = (state == DRAIN);
  assign bus.out_valid    = ov_q;
  assign bus.out_data     = od_q;
  assign bus.out_row      = orow_q;
  assign bus.conflict_err = err_q;
endmodule

// File: tb/tb_acc_multibank.sv
`timescale 1ns/1ps
module tb_acc_multibank;
  localparam int NB   = 4;
  localparam int ROWS = 16;
  localparam int COLS = 8;
  localparam int W    = 32;
  localparam int LAT  = 2;
  localparam int DW   = COLS * W;
  localparam int RW   = $clog2(ROWS);

  typedef logic [DW-1:0] row_t;
  typedef struct packed {
    logic [RW-1:0] row;
    row_t          dat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  acc_multibank_if #(.NUM_BANKS(NB), .ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(W)) bus();

  acc_multibank #(.NUM_BANKS(NB), .ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(W), .ACC_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   hs_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic stall_prev = 1'b0;
  row_t stall_dat;
  logic [RW-1:0] stall_row;
  logic [W-1:0]  ov0, relu0;
  int   h0;

  task automatic chk(input string name, input row_t act, input row_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected row per handshake and checks stall stability.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1) begin
      if (stall_prev) begin
        chk("stall_data", bus.out_data, stall_dat);
        chk("stall_row", DW'(bus.out_row), DW'(stall_row));
      end
      if (bus.out_ready) begin
        hs_cnt++;
        stall_prev = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_row: got row %0d, required no output", bus.out_row);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_row", DW'(bus.out_row), DW'(mon_e.row));
          chk("out_data", bus.out_data, mon_e.dat);
        end
      end else begin
        stall_prev = 1'b1;
        stall_dat  = bus.out_data;
        stall_row  = bus.out_row;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int r, input row_t d);
    exp_q.push_back({RW'(r), d});
  endtask

  task automatic do_bias(input int b, input row_t d);
    bus.bias_valid = 1'b1;
    bus.bias_bank  = 2'(b);
    bus.bias_data  = d;
    tick();
    bus.bias_valid = 1'b0;
  endtask

  task automatic do_acc(input int b, input row_t d);
    bus.acc_valid = 1'b1;
    bus.acc_bank  = 2'(b);
    bus.acc_data  = d;
    tick();
    bus.acc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.drain_busy && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_busy_end"}, DW'(bus.drain_busy), DW'(0));
    chk({name, "_valid_end"}, DW'(bus.out_valid), DW'(0));
  endtask

  task automatic drain(input string name, input int b, input logic relu);
    bus.relu_en     = relu;
    bus.drain_bank  = 2'(b);
    bus.drain_start = 1'b1;
    bus.out_ready   = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    chk({name, "_busy_start"}, DW'(bus.drain_busy), DW'(1));
    wait_idle(name);
  endtask

  function automatic row_t ramp(input int base);
    row_t r;
    for (int l = 0; l < COLS; l++) r[l*W +: W] = W'(base + l);
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.acc_valid = 1'b0;   bus.acc_bank = '0;   bus.acc_data = '0;
    bus.bias_valid = 1'b0;  bus.bias_bank = '0;  bus.bias_data = '0;
    bus.relu_en = 1'b0;     bus.drain_start = 1'b0; bus.drain_bank = '0;
    bus.out_ready = 1'b1;   bus.err_clear = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("rst_drain_busy", DW'(bus.drain_busy), DW'(0));
    chk("rst_conflict", DW'(bus.conflict_err), DW'(0));
    chk("rst_out_row", DW'(bus.out_row), DW'(0));
    chk("rst_out_data", bus.out_data, '0);
    reset = 1'b1;
    tick();

    // Basic: bias r, two accumulate passes of +1 -> r+2; then the bank reads back zero.
    for (int r = 0; r < ROWS; r++) do_bias(1, {COLS{W'(r)}});
    for (int i = 0; i < 2 * ROWS; i++) do_acc(1, {COLS{W'(1)}});
    repeat (4) tick();
    for (int r = 0; r < ROWS; r++) push_row(r, {COLS{W'(r + 2)}});
    drain("basic", 1, 1'b0);
    for (int r = 0; r < ROWS; r++) push_row(r, '0);
    drain("basic_clear", 1, 1'b0);

    // Backpressure: ready toggles every cycle, ROWS handshakes in 2*ROWS cycles.
    for (int r = 0; r < ROWS; r++) do_bias(2, {COLS{W'(100 + r)}});
    for (int r = 0; r < ROWS; r++) push_row(r, {COLS{W'(100 + r)}});
    bus.out_ready   = 1'b0;
    bus.drain_bank  = 2'd2;
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    h0 = hs_cnt;
    for (int i = 0; i < 2 * ROWS; i++) begin
      bus.out_ready = (i % 2 == 0);
      tick();
    end
    chk("bp_handshakes", DW'(hs_cnt - h0), DW'(ROWS));
    chk("bp_busy_end", DW'(bus.drain_busy), DW'(0));
    bus.out_ready = 1'b1;

    // Overlap: drain bank 0 while accumulating bank 2 every cycle.
    for (int r = 0; r < ROWS; r++) do_bias(0, ramp(r * 8));
    for (int r = 0; r < ROWS; r++) push_row(r, ramp(r * 8));
    bus.drain_bank  = 2'd0;
    bus.drain_start = 1'b1;
    do_acc(2, ramp(1));
    bus.drain_start = 1'b0;
    for (int i = 1; i < ROWS; i++) do_acc(2, ramp(1));
    wait_idle("overlap");
    chk("overlap_err", DW'(bus.conflict_err), DW'(0));
    repeat (3) tick();
    for (int r = 0; r < ROWS; r++) push_row(r, ramp(1));
    drain("overlap_b2", 2, 1'b0);

    // Conflicts during a stalled drain of bank 1.
    bus.out_ready   = 1'b0;
    bus.drain_bank  = 2'd1;
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    do_acc(1, {COLS{W'(1)}});
    chk("err_acc_drain", DW'(bus.conflict_err), DW'(1));
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    chk("err_clear", DW'(bus.conflict_err), DW'(0));
    bus.drain_bank  = 2'd0;
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    chk("err_start_busy", DW'(bus.conflict_err), DW'(1));
    bus.err_clear = 1'b1;
    do_acc(1, {COLS{W'(1)}});
    bus.err_clear = 1'b0;
    chk("err_clear_prio", DW'(bus.conflict_err), DW'(0));
    for (int r = 0; r < ROWS; r++) push_row(r, '0);
    bus.out_ready = 1'b1;
    wait_idle("conflict_drain");

    // Same-cycle acc + bias to bank 3: bias dropped, pointer advances once.
    bus.acc_valid  = 1'b1; bus.acc_bank  = 2'd3; bus.acc_data  = {COLS{W'(4)}};
    bus.bias_valid = 1'b1; bus.bias_bank = 2'd3; bus.bias_data = {COLS{W'(99)}};
    tick();
    bus.acc_valid  = 1'b0;
    bus.bias_valid = 1'b0;
    chk("err_acc_bias", DW'(bus.conflict_err), DW'(1));
    do_bias(3, {COLS{W'(50)}});
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    chk("err_clear2", DW'(bus.conflict_err), DW'(0));
    repeat (3) tick();
    push_row(0, {COLS{W'(4)}});
    push_row(1, {COLS{W'(50)}});
    for (int r = 2; r < ROWS; r++) push_row(r, '0);
    drain("bank3", 3, 1'b0);

    // Overflow: 0x7FFFFFF0 + 0x20 on lane 0, +1 on other lanes.
`ifdef ACC_SAT_EN
    ov0   = 32'h7FFFFFFF;
    relu0 = 32'h7FFFFFFF;
`else
    ov0   = 32'h80000010;
    relu0 = 32'h00000000;
`endif
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < ROWS; r++) do_bias(b, {COLS{32'h7FFFFFF0}});
      for (int r = 0; r < ROWS; r++) do_acc(b, {{(COLS-1){32'h00000001}}, 32'h00000020});
    end
    repeat (4) tick();
    for (int r = 0; r < ROWS; r++) push_row(r, {{(COLS-1){32'h7FFFFFF1}}, ov0});
    drain("ovf", 0, 1'b0);
    for (int r = 0; r < ROWS; r++) push_row(r, {{(COLS-1){32'h7FFFFFF1}}, relu0});
    drain("ovf_relu", 1, 1'b1);

    tick();
    chk("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
